// File: rtl/note_sequencer.sv
// Note sequencer: queues (frequency, duration) commands and plays them on the sound_chip voice.
// Optional rests (frequency 0 keeps the voice silent) are enabled by defining NOTE_SEQ_REST_EN.
module note_sequencer #(
   parameter int unsigned FREQ_W    = 16,
   parameter int unsigned DUR_W     = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned TICK_DIV  = 1000,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic                     CLK_IN,
   input  logic                     RESET,
   input  logic                     START,
   input  logic                     STOP,
   input  logic                     CMD_VALID,
   output logic                     CMD_READY,
   input  logic [FREQ_W-1:0]        CMD_FREQ,
   input  logic [DUR_W-1:0]         CMD_DUR,
   output logic [FREQ_W-1:0]        FREQ_OUT,
   output logic                     EN_OUT,
   output logic                     BUSY,
   output logic                     NOTE_DONE,
   output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef NOTE_SEQ_REST_EN
   localparam bit REST_EN = 1'b1;
`else
   localparam bit REST_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

   logic [FREQ_W-1:0] freq_mem [DEPTH];
   logic [DUR_W-1:0]  dur_mem  [DEPTH];

   state_e            state_q;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [TICK_W-1:0] tick_q;
   logic [DUR_W-1:0]  dur_q;

   logic              push, pop, tick_wrap, run_end, head_rest;
   logic [PTR_W-1:0]  next_ptr;
   logic [FREQ_W-1:0] head_freq;
   logic [DUR_W-1:0]  head_dur, next_dur;

   assign CMD_READY = (FIFO_COUNT < CNT_W'(DEPTH)) && !STOP;
   assign push      = CMD_VALID && CMD_READY;
   assign pop       = (state_q == LOAD) && !STOP;
   assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
   assign run_end   = tick_wrap && (dur_q == DUR_W'(1));
   assign head_freq = freq_mem[rd_ptr_q];
   assign head_dur  = dur_mem[rd_ptr_q];
   assign head_rest = REST_EN && (head_freq == '0);
   // Entry that the upcoming LOAD will pop; lets a zero-length note flag NOTE_DONE in its LOAD cycle
   assign next_ptr  = (state_q == LOAD) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
   assign next_dur  = dur_mem[next_ptr];

   always_ff @(posedge CLK_IN) begin
      if (push) begin
         freq_mem[wr_ptr_q] <= CMD_FREQ;
         dur_mem[wr_ptr_q]  <= CMD_DUR;
      end
   end

   always_ff @(posedge CLK_IN or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         FIFO_COUNT <= '0;
         tick_q     <= '0;
         dur_q      <= '0;
         FREQ_OUT   <= '0;
         EN_OUT     <= 1'b0;
         BUSY       <= 1'b0;
         NOTE_DONE  <= 1'b0;
      end else begin
         NOTE_DONE <= 1'b0;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         FIFO_COUNT <= FIFO_COUNT + CNT_W'(push) - CNT_W'(pop);
         if (STOP) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            FIFO_COUNT <= '0;
            tick_q     <= '0;
            dur_q      <= '0;
            EN_OUT     <= 1'b0;
            BUSY       <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (START && FIFO_COUNT != '0) begin
                     state_q   <= LOAD;
                     BUSY      <= 1'b1;
                     NOTE_DONE <= (next_dur == '0);
                  end
               end
               LOAD: begin
                  tick_q <= '0;
                  dur_q  <= head_dur;
                  if (!head_rest) FREQ_OUT <= head_freq;
                  if (head_dur == '0) begin
                     if (FIFO_COUNT > CNT_W'(1)) begin
                        state_q   <= LOAD;
                        NOTE_DONE <= (next_dur == '0);
                     end else begin
                        state_q <= IDLE;
                        BUSY    <= 1'b0;
                     end
                  end else begin
                     state_q <= PLAY;
                     EN_OUT  <= !head_rest;
                  end
               end
               PLAY, GAP: begin
                  // Both states time out in whole ticks; dur_q holds the remaining ticks
                  tick_q <= tick_wrap ? '0 : tick_q + TICK_W'(1);
                  if (tick_wrap) dur_q <= dur_q - DUR_W'(1);
                  if (run_end) begin
                     EN_OUT <= 1'b0;
                     if (state_q == PLAY && GAP_TICKS != 0) begin
                        state_q   <= GAP;
                        dur_q     <= DUR_W'(GAP_TICKS);
                        NOTE_DONE <= 1'b1;
                     end else begin
                        NOTE_DONE <= (state_q == PLAY) ||
                                     (FIFO_COUNT != '0 && next_dur == '0);
                        if (FIFO_COUNT != '0) begin
                           state_q <= LOAD;
                        end else begin
                           state_q <= IDLE;
                           BUSY    <= 1'b0;
                        end
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Command-driven controller for the sound_chip voice: buffers (frequency, duration) note commands in a small FIFO and plays them in order.
- Drives the voice's frequency and enable inputs, with a timed silent gap between notes.
- Sits between the register/CPU side, which pushes commands, and the sound_chip FREQ_IN/EN inputs.

Parameters:
- FREQ_W, 16, width of frequency word; matches the sound_chip frequency input.
- DUR_W, 8, width of note duration field, in ticks.
- DEPTH, 8, command FIFO depth; must be a power of 2, at least 2.
- TICK_DIV, 1000, CLK_IN cycles per duration tick; must be at least 1.
- GAP_TICKS, 1, silent ticks inserted after every note; 0 is legal.

Ports:
- CLK_IN  in  1  system clock, all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle pulse that starts playback of the queued notes.
- STOP  in  1  single-cycle pulse that aborts playback and flushes the FIFO.
- CMD_VALID  in  1  note command valid.
- CMD_READY  out  1  FIFO can accept a command.
- CMD_FREQ  in  FREQ_W  note frequency word.
- CMD_DUR  in  DUR_W  note length in ticks.
- FREQ_OUT  out  FREQ_W  frequency to sound_chip FREQ_IN.
- EN_OUT  out  1  enable to sound_chip EN.
- BUSY  out  1  high in any state other than IDLE.
- NOTE_DONE  out  1  one-cycle pulse when a note finishes or is skipped.
- FIFO_COUNT  out  $clog2(DEPTH)+1  number of entries currently queued.

Behaviour:
- Reset:
  - RESET is asynchronous and active-high.
  - Outputs: FREQ_OUT=0, EN_OUT=0, BUSY=0, NOTE_DONE=0, FIFO_COUNT=0.
  - Internal: state=IDLE, FIFO pointers=0, tick and duration counters=0.
  - Reset asserted mid-note drops EN_OUT immediately and discards all queued commands.
- FIFO:
  - CMD_READY = (FIFO_COUNT < DEPTH) && !STOP.
  - A push occurs when CMD_VALID && CMD_READY.
  - Push and pop in the same cycle leave the count unchanged, and the data is preserved in order.
  - When full, CMD_READY=0 and the command is held off; no command is ever dropped.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE, LOAD, PLAY, GAP):
  - IDLE:
    - EN_OUT=0, FREQ_OUT holds its last value.
    - START with FIFO_COUNT>0 moves to LOAD next cycle.
    - START with an empty FIFO is ignored.
    - START while not in IDLE is ignored.
  - LOAD (1 cycle):
    - Pop the head entry; FREQ_OUT <= CMD_FREQ of the entry; duration counter <= CMD_DUR; tick counter <= 0.
    - If the popped duration is 0: pulse NOTE_DONE, EN_OUT stays 0, and go to LOAD if the FIFO is still non-empty, otherwise IDLE.
    - Otherwise go to PLAY.
  - PLAY:
    - EN_OUT=1.
    - The tick counter counts 0..TICK_DIV-1; on wrap the duration counter decrements.
    - When the duration counter decrements 1 to 0: EN_OUT falls next cycle, NOTE_DONE pulses in that cycle, and the state becomes GAP, or bypasses GAP when GAP_TICKS=0.
  - GAP:
    - EN_OUT=0 for exactly GAP_TICKS*TICK_DIV cycles.
    - Then go to LOAD if FIFO_COUNT>0, else IDLE.
- Latency and timing:
  - START sampled in cycle n: LOAD in n+1, EN_OUT=1 from n+2.
  - EN_OUT stays high for exactly CMD_DUR*TICK_DIV cycles per note.
  - Between consecutive notes, EN_OUT is low for exactly GAP_TICKS*TICK_DIV+1 cycles.
- Late pushes: a command pushed during PLAY or GAP is played in the same run. No new START is needed.
- STOP:
  - From any state, next cycle: state=IDLE, EN_OUT=0, FIFO flushed (FIFO_COUNT=0), counters cleared. FREQ_OUT is held.
  - STOP has priority over START in the same cycle.
  - NOTE_DONE does not pulse for an aborted note.

Optional Feature:
- Macro: NOTE_SEQ_REST_EN.
- When defined:
  - A note with CMD_FREQ==0 is a rest: it is timed exactly like a note, but EN_OUT stays 0 during PLAY and FREQ_OUT keeps its previous value.
  - NOTE_DONE pulses normally at the end of the rest.
- When undefined: frequency 0 is played like any other note, with EN_OUT=1 and FREQ_OUT=0.

Test Plan:
- Setup for all tests: TICK_DIV=4, GAP_TICKS=1, DEPTH=8.
- Reset then single note: push (freq 0x0100, dur 3), START in cycle 10 -> EN_OUT=1 in cycles 12..23 (12 cycles), FREQ_OUT=0x0100, NOTE_DONE pulses in cycle 24, BUSY=0 from cycle 28.
- Back-to-back notes: push (0x0100,2) and (0x0200,1), START -> first EN_OUT window 8 cycles, low 5 cycles, second window 4 cycles at FREQ_OUT=0x0200, two NOTE_DONE pulses.
- FIFO full: push 9 commands without START -> CMD_READY=0 after the 8th, FIFO_COUNT=8; after START and first LOAD, the 9th command is accepted and CMD_READY=1.
- Zero duration: queue (0x0300,0), then (0x0400,1) -> no EN_OUT for the first, NOTE_DONE pulse in its LOAD cycle, second plays 4 cycles.
- STOP mid-note: 3 notes queued, STOP in 2nd PLAY cycle -> EN_OUT=0 and FIFO_COUNT=0 next cycle, BUSY=0, no NOTE_DONE; a later START does nothing.
- RESET asserted asynchronously mid-PLAY -> EN_OUT=0 and FREQ_OUT=0 without a clock edge. With NOTE_SEQ_REST_EN: (0,2) gives EN_OUT=0 for 8 cycles, then NOTE_DONE.
